// File: rtl/cpu_pkg.sv
// Shared CPU constants and types used by the fetch buffer and its storage.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W = 16;
    localparam int unsigned CPU_ADDR_W = 16;
    localparam int unsigned CPU_FLAG_W = 5;
    localparam int unsigned FB_DEPTH   = 4;

    // One queued fetch: instruction word plus the PC it was fetched from.
    typedef struct packed {
        logic [CPU_DATA_W-1:0] instr;
        logic [CPU_ADDR_W-1:0] pc;
    } fb_entry_t;

    // Occupancy class of the queue; there is no other state beyond the pointers.
    typedef enum logic [1:0] {
        FbEmpty   = 2'd0,
        FbPartial = 2'd1,
        FbFull    = 2'd2
    } fb_level_e;

    // Classify occupancy from the pointer-derived empty/full indications.
    function automatic fb_level_e fb_level_of(input logic empty, input logic full);
        fb_level_e lvl;
        if (empty) begin
            lvl = FbEmpty;
        end else if (full) begin
            lvl = FbFull;
        end else begin
            lvl = FbPartial;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/fetch_buffer_regfile.sv
// Storage array for the fetch buffer: one write port, one asynchronous read port.
// The array is deliberately not reset; validity is tracked by the pointers.
module fetch_buffer_regfile
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = FB_DEPTH,
    parameter int unsigned WIDTH = CPU_DATA_W + CPU_ADDR_W
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read of the addressed entry.
    always_comb begin
        rd_data = mem[rd_addr];
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch queue between instruction memory and the FSM/decoder,
// plus the saved-PSR flag register.
// Pointers are one bit wider than the index so full and empty are distinguishable.
module fetch_buffer
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DEPTH  = FB_DEPTH,
    parameter int unsigned FLAG_W = CPU_FLAG_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_valid,
    input  logic [DATA_W-1:0]      fetch_instr,
    input  logic [ADDR_W-1:0]      fetch_pc,
    output logic                   fetch_ready,
    output logic                   issue_valid,
    output logic [DATA_W-1:0]      issue_instr,
    output logic [ADDR_W-1:0]      issue_pc,
    input  logic                   issue_ready,
    input  logic                   flush,
    input  logic                   flag_load,
    input  logic [FLAG_W-1:0]      flag_in,
    output logic [FLAG_W-1:0]      flags_q,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop_err
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned PTR_W   = IDX_W + 1;
    localparam int unsigned ENTRY_W = DATA_W + ADDR_W;
    localparam logic [PTR_W-1:0] PTR_STEP = PTR_W'(1);

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               empty;
    logic               full;
    fb_level_e          level;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Occupancy from pointer comparison; count wraps naturally modulo 2*DEPTH.
    always_comb begin
        empty = (rd_ptr == wr_ptr);
        full  = (rd_ptr[IDX_W] != wr_ptr[IDX_W]) &&
                (rd_ptr[IDX_W-1:0] == wr_ptr[IDX_W-1:0]);
        level = fb_level_of(empty, full);
        count = wr_ptr - rd_ptr;
    end

    // Handshakes; flush blocks both sides, and a same-cycle pop never frees a slot early.
    always_comb begin
        fetch_ready = (level != FbFull) && !flush;
        issue_valid = (level != FbEmpty);
        push        = fetch_valid && fetch_ready;
        pop         = issue_valid && issue_ready && !flush;
    end

    // Pack the incoming fetch and unpack the head entry; head reads as zero when empty.
    always_comb begin
        wr_entry = {fetch_instr, fetch_pc};
        if (issue_valid) begin
            issue_instr = rd_entry[ENTRY_W-1:ADDR_W];
            issue_pc    = rd_entry[ADDR_W-1:0];
        end else begin
            issue_instr = '0;
            issue_pc    = '0;
        end
    end

    fetch_buffer_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_regfile (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr[IDX_W-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr[IDX_W-1:0]),
        .rd_data (rd_entry)
    );

    // Pointer update: reset, then flush, then independent push/pop advance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_STEP;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_STEP;
            end
        end
    end

    // Sticky overflow flag: a refused fetch outside a flush is a lost instruction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop_err <= 1'b0;
        end else if (fetch_valid && !fetch_ready && !flush) begin
            drop_err <= 1'b1;
        end
    end

    // Saved-PSR flags; independent of flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q <= '0;
        end else if (flag_load) begin
            flags_q <= flag_in;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fetch_buffer;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [15:0] fetch_instr;
    logic [15:0] fetch_pc;
    logic        fetch_ready;
    logic        issue_valid;
    logic [15:0] issue_instr;
    logic [15:0] issue_pc;
    logic        issue_ready;
    logic        flush;
    logic        flag_load;
    logic [4:0]  flag_in;
    logic [4:0]  flags_q;
    logic [2:0]  count;
    logic        drop_err;

    always #10 clk = ~clk;

    fetch_buffer #(
        .DATA_W (16),
        .ADDR_W (16),
        .DEPTH  (DEPTH),
        .FLAG_W (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_ready (fetch_ready),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_pc    (issue_pc),
        .issue_ready (issue_ready),
        .flush       (flush),
        .flag_load   (flag_load),
        .flag_in     (flag_in),
        .flags_q     (flags_q),
        .count       (count),
        .drop_err    (drop_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    fb_entry_t   mq[$];
    logic [4:0]  m_flags;
    logic        m_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle();
        reset       = 1'b1;
        fetch_valid = 1'b0;
        fetch_instr = '0;
        fetch_pc    = '0;
        issue_ready = 1'b0;
        flush       = 1'b0;
        flag_load   = 1'b0;
        flag_in     = '0;
    endtask

    // Compare DUT against model with the current inputs applied, then advance both one edge.
    task automatic step();
        fb_entry_t e;
        logic      room;
        #1;
        room = (mq.size() < DEPTH);
        check_eq("count", 32'(count), mq.size());
        check_eq("issue_valid", 32'(issue_valid), (mq.size() != 0) ? 1 : 0);
        check_eq("issue_instr", 32'(issue_instr), (mq.size() != 0) ? 32'(mq[0].instr) : 0);
        check_eq("issue_pc", 32'(issue_pc), (mq.size() != 0) ? 32'(mq[0].pc) : 0);
        check_eq("fetch_ready", 32'(fetch_ready), (room && !flush) ? 1 : 0);
        check_eq("flags_q", 32'(flags_q), 32'(m_flags));
        check_eq("drop_err", 32'(drop_err), 32'(m_err));
        if (!reset) begin
            mq.delete();
            m_flags = '0;
            m_err   = 1'b0;
        end else begin
            if (flush) begin
                mq.delete();
            end else begin
                if (fetch_valid && !room) m_err = 1'b1;
                if (issue_ready && mq.size() != 0) void'(mq.pop_front());
                if (fetch_valid && room) begin
                    e.instr = fetch_instr;
                    e.pc    = fetch_pc;
                    mq.push_back(e);
                end
            end
            if (flag_load) m_flags = flag_in;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        idle();
        // Reset held two cycles with a fetch pending; first edge brings state out of X.
        reset       = 1'b0;
        fetch_valid = 1'b1;
        fetch_instr = 16'hdead;
        @(posedge clk);
        @(negedge clk);
        mq.delete();
        m_flags = '0;
        m_err   = 1'b0;
        step();
        idle();
        #1;
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_issue_valid", 32'(issue_valid), 0);
        check_eq("rst_flags", 32'(flags_q), 0);
        check_eq("rst_drop_err", 32'(drop_err), 0);
        check_eq("rst_fetch_ready", 32'(fetch_ready), 1);

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            fetch_valid = 1'b1;
            fetch_instr = 16'h1001 + 16'(i);
            fetch_pc    = 16'(i);
            step();
        end
        idle();
        #1;
        check_eq("fill_count", 32'(count), 4);
        check_eq("fill_ready", 32'(fetch_ready), 0);
        fetch_valid = 1'b1;
        fetch_instr = 16'h1005;
        fetch_pc    = 16'd4;
        step();
        idle();
        #1;
        check_eq("ovf_drop_err", 32'(drop_err), 1);
        check_eq("ovf_head_instr", 32'(issue_instr), 32'h1001);
        check_eq("ovf_head_pc", 32'(issue_pc), 0);

        // Drain, then stream one word per cycle well past 2*DEPTH
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            issue_ready = 1'b1;
            step();
        end
        for (int i = 0; i < 3 * DEPTH; i++) begin
            idle();
            issue_ready = 1'b1;
            fetch_valid = 1'b1;
            fetch_instr = 16'h1001 + 16'(i);
            fetch_pc    = 16'(i);
            step();
            if (i > 0) check_eq("stream_count", 32'(count), 1);
        end

        // Build up to 3 entries, then flush with push and pop both requested
        for (int i = 0; i < 2; i++) begin
            idle();
            fetch_valid = 1'b1;
            fetch_instr = 16'h3000 + 16'(i);
            fetch_pc    = 16'h40 + 16'(i);
            step();
        end
        idle();
        #1;
        check_eq("pre_flush_count", 32'(count), 3);
        flush       = 1'b1;
        fetch_valid = 1'b1;
        issue_ready = 1'b1;
        fetch_instr = 16'hbad0;
        step();
        idle();
        #1;
        check_eq("flush_count", 32'(count), 0);
        check_eq("flush_issue_valid", 32'(issue_valid), 0);
        check_eq("flush_drop_err", 32'(drop_err), 1);
        fetch_valid = 1'b1;
        fetch_instr = 16'h2000;
        fetch_pc    = 16'h0100;
        step();
        idle();
        #1;
        check_eq("post_flush_instr", 32'(issue_instr), 32'h2000);
        step();

        // Flags: load, then hold through a flush
        flag_load = 1'b1;
        flag_in   = 5'b10110;
        step();
        idle();
        flag_in = 5'b00001;
        flush   = 1'b1;
        step();
        idle();
        #1;
        check_eq("flags_hold", 32'(flags_q), 32'b10110);

        // Reset mid-stream with 2 entries and push+pop+flag_load all active
        for (int i = 0; i < 2; i++) begin
            idle();
            fetch_valid = 1'b1;
            fetch_instr = 16'h5000 + 16'(i);
            fetch_pc    = 16'(i);
            step();
        end
        idle();
        reset       = 1'b0;
        fetch_valid = 1'b1;
        issue_ready = 1'b1;
        flag_load   = 1'b1;
        flag_in     = 5'h1f;
        step();
        idle();
        #1;
        check_eq("mid_rst_count", 32'(count), 0);
        check_eq("mid_rst_valid", 32'(issue_valid), 0);
        check_eq("mid_rst_instr", 32'(issue_instr), 0);
        check_eq("mid_rst_flags", 32'(flags_q), 0);
        check_eq("mid_rst_err", 32'(drop_err), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            reset       = ($urandom_range(0, 99) >= 2);
            fetch_valid = ($urandom_range(0, 99) < 70);
            fetch_instr = 16'($urandom);
            fetch_pc    = 16'($urandom);
            issue_ready = ($urandom_range(0, 99) < 50);
            flush       = ($urandom_range(0, 99) < 5);
            flag_load   = ($urandom_range(0, 99) < 20);
            flag_in     = 5'($urandom);
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
